// File: rtl/ctrl_pipe.sv
// Control pipeline for a 4-bit-opcode core: opcode decode, a STAGES-deep chain of
// control registers with stall/flush, a halt drain FSM and a retired-instruction counter.

package ctrl_pipe_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROR = 4'b0110;
    localparam logic [OP_W-1:0] OP_LW  = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LLB = 4'b1010;
    localparam logic [OP_W-1:0] OP_LHB = 4'b1011;
    localparam logic [OP_W-1:0] OP_B   = 4'b1100;
    localparam logic [OP_W-1:0] OP_BR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_PCS = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Full control bundle carried by stages 1..STAGES-1
    typedef struct packed {
        logic               valid;
        logic               hlt;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               load_partial;
        logic               flag_nv_en;
        logic               flag_z_en;
        logic               branch;
        logic               branch_reg;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               save_pc;
    } ctrl_t;

    // Write-back stage only needs the tail of the bundle
    typedef struct packed {
        logic valid;
        logic hlt;
        logic reg_write;
        logic mem_to_reg;
        logic save_pc;
    } wb_t;

    localparam ctrl_t BUBBLE    = '0;
    localparam wb_t   WB_BUBBLE = '0;

    function automatic ctrl_t decode(input logic [OP_W-1:0] op);
        ctrl_t d;
        d              = BUBBLE;
        d.valid        = 1'b1;
        d.hlt          = (op == OP_HLT);
        d.alu_op       = op[3] ? '0 : op[ALUOP_W-1:0];
        d.alu_src      = op[3] | (op == OP_SLL) | (op == OP_SRA) | (op == OP_ROR);
        d.load_partial = (op == OP_LLB) | (op == OP_LHB);
        d.flag_nv_en   = (op == OP_ADD) | (op == OP_SUB);
        d.flag_z_en    = (op == OP_ADD) | (op == OP_SUB) | (op == OP_XOR) |
                         (op == OP_SLL) | (op == OP_SRA) | (op == OP_ROR);
        d.branch       = (op == OP_B) | (op == OP_BR);
        d.branch_reg   = (op == OP_BR);
        d.mem_read     = (op == OP_LW);
        d.mem_write    = (op == OP_SW);
        d.reg_write    = ~op[3] | (op == OP_LW) | (op == OP_LLB) |
                         (op == OP_LHB) | (op == OP_PCS);
        d.mem_to_reg   = (op == OP_LW);
        d.save_pc      = (op == OP_PCS);
        return d;
    endfunction

endpackage

module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned STAGES = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             accept,
    output logic [2:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_load_partial,
    output logic             ex_flag_nv_en,
    output logic             ex_flag_z_en,
    output logic             ex_branch,
    output logic             ex_branch_reg,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic             wb_save_pc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned PIPE_N  = STAGES - 1;
    localparam int unsigned MEM_IDX = STAGES - 2;

    state_t state_q;
    state_t state_d;
    logic   halted_d;
    logic   run_c;

    ctrl_t  pipe_q [PIPE_N];
    ctrl_t  pipe_d [PIPE_N];
    ctrl_t  s1_d;
    ctrl_t  s2_d;
    wb_t    last_q;
    wb_t    last_d;

    assign accept = in_valid & ~stall & ~flush & run_c;

    // Stage 1/2 steering: flush kills stage 1 outright, stall holds it and feeds a bubble onward
    always_comb begin
        s1_d = BUBBLE;
        s2_d = pipe_q[0];
        if (flush) begin
            s1_d = BUBBLE;
            s2_d = BUBBLE;
        end else if (stall) begin
            s1_d = pipe_q[0];
            s2_d = BUBBLE;
        end else if (accept) begin
            s1_d = decode(opcode);
        end
    end

    assign pipe_d[0] = s1_d;
    assign pipe_d[1] = s2_d;

    for (genvar g = 2; g < PIPE_N; g++) begin : g_shift
        assign pipe_d[g] = pipe_q[g-1];
    end

    always_comb begin
        last_d            = WB_BUBBLE;
        last_d.valid      = pipe_q[MEM_IDX].valid;
        last_d.hlt        = pipe_q[MEM_IDX].hlt;
        last_d.reg_write  = pipe_q[MEM_IDX].reg_write;
        last_d.mem_to_reg = pipe_q[MEM_IDX].mem_to_reg;
        last_d.save_pc    = pipe_q[MEM_IDX].save_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '{default: '0};
            last_q <= WB_BUBBLE;
        end else begin
            pipe_q <= pipe_d;
            last_q <= last_d;
        end
    end

    // Bubbles carry all-zero controls, so outputs come straight off the stage registers
    assign ex_alu_op       = pipe_q[0].alu_op;
    assign ex_alu_src      = pipe_q[0].alu_src;
    assign ex_load_partial = pipe_q[0].load_partial;
    assign ex_flag_nv_en   = pipe_q[0].flag_nv_en;
    assign ex_flag_z_en    = pipe_q[0].flag_z_en;
    assign ex_branch       = pipe_q[0].branch;
    assign ex_branch_reg   = pipe_q[0].branch_reg;
    assign mem_read        = pipe_q[MEM_IDX].mem_read;
    assign mem_write       = pipe_q[MEM_IDX].mem_write;
    assign wb_reg_write    = last_q.reg_write;
    assign wb_mem_to_reg   = last_q.mem_to_reg;
    assign wb_save_pc      = last_q.save_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (last_q.valid) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Halt FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            halted  <= halted_d;
        end
    end

    // Halt FSM: next state; a flush only rescues the HLT while it still sits in stage 1
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && (opcode == OP_HLT)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_q.valid && last_q.hlt) begin
                    state_d = ST_HALTED;
                end else if (flush && pipe_q[0].valid && pipe_q[0].hlt) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Halt FSM: outputs
    always_comb begin
        run_c    = (state_q == ST_RUN);
        halted_d = (state_d == ST_HALTED);
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: one STAGES=3/CNT_W=16 instance and one STAGES=5/CNT_W=4 instance.

module tb_ctrl_pipe;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst_n, a_in_valid, a_stall, a_flush;
    logic [3:0]  a_opcode;
    logic        a_accept, a_ex_alu_src, a_ex_load_partial, a_ex_flag_nv_en, a_ex_flag_z_en;
    logic        a_ex_branch, a_ex_branch_reg, a_mem_read, a_mem_write;
    logic        a_wb_reg_write, a_wb_mem_to_reg, a_wb_save_pc, a_halted;
    logic [2:0]  a_ex_alu_op;
    logic [15:0] a_retired;

    logic        b_rst_n, b_in_valid, b_stall, b_flush;
    logic [3:0]  b_opcode;
    logic        b_accept, b_ex_alu_src, b_ex_load_partial, b_ex_flag_nv_en, b_ex_flag_z_en;
    logic        b_ex_branch, b_ex_branch_reg, b_mem_read, b_mem_write;
    logic        b_wb_reg_write, b_wb_mem_to_reg, b_wb_save_pc, b_halted;
    logic [2:0]  b_ex_alu_op;
    logic [3:0]  b_retired;

    int acc_cnt;

    ctrl_pipe #(.STAGES(3), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(a_rst_n), .opcode(a_opcode), .in_valid(a_in_valid),
        .stall(a_stall), .flush(a_flush), .accept(a_accept),
        .ex_alu_op(a_ex_alu_op), .ex_alu_src(a_ex_alu_src), .ex_load_partial(a_ex_load_partial),
        .ex_flag_nv_en(a_ex_flag_nv_en), .ex_flag_z_en(a_ex_flag_z_en), .ex_branch(a_ex_branch),
        .ex_branch_reg(a_ex_branch_reg), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .wb_reg_write(a_wb_reg_write), .wb_mem_to_reg(a_wb_mem_to_reg), .wb_save_pc(a_wb_save_pc),
        .halted(a_halted), .retired(a_retired)
    );

    ctrl_pipe #(.STAGES(5), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(b_rst_n), .opcode(b_opcode), .in_valid(b_in_valid),
        .stall(b_stall), .flush(b_flush), .accept(b_accept),
        .ex_alu_op(b_ex_alu_op), .ex_alu_src(b_ex_alu_src), .ex_load_partial(b_ex_load_partial),
        .ex_flag_nv_en(b_ex_flag_nv_en), .ex_flag_z_en(b_ex_flag_z_en), .ex_branch(b_ex_branch),
        .ex_branch_reg(b_ex_branch_reg), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .wb_reg_write(b_wb_reg_write), .wb_mem_to_reg(b_wb_mem_to_reg), .wb_save_pc(b_wb_save_pc),
        .halted(b_halted), .retired(b_retired)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand table {alu_op, alu_src, load_partial, nv, z, branch, branch_reg}; 0 for bubbles
    function automatic logic [8:0] exp_ex(input int op);
        case (op)
            0:  return 9'h00C;
            1:  return 9'h04C;
            2:  return 9'h084;
            3:  return 9'h0C0;
            4:  return 9'h124;
            5:  return 9'h164;
            6:  return 9'h1A4;
            7:  return 9'h1C0;
            8:  return 9'h020;
            9:  return 9'h020;
            10: return 9'h030;
            11: return 9'h030;
            12: return 9'h022;
            13: return 9'h023;
            14: return 9'h020;
            default: return 9'h000;
        endcase
    endfunction

    // {mem_read, mem_write}
    function automatic logic [1:0] exp_mem(input int op);
        case (op)
            8:       return 2'b10;
            9:       return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // {reg_write, mem_to_reg, save_pc}
    function automatic logic [2:0] exp_wb(input int op);
        case (op)
            0, 1, 2, 3, 4, 5, 6, 7, 10, 11: return 3'b100;
            8:                              return 3'b110;
            14:                             return 3'b101;
            default:                        return 3'b000;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of the sequence");
        $fatal(1, "time limit");
    end

    initial begin
        a_rst_n = 1'b1; a_opcode = 4'h0; a_in_valid = 1'b0; a_stall = 1'b0; a_flush = 1'b0;
        b_rst_n = 1'b1; b_opcode = 4'h0; b_in_valid = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
        acc_cnt = 0;

        // Asynchronous reset before any clock edge
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        check("rst_retired", 32'(a_retired), 32'd0);
        check("rst_halted", 32'(a_halted), 32'd0);
        check("rst_ctrl", 32'({a_ex_alu_op, a_ex_alu_src, a_mem_read, a_mem_write, a_wb_reg_write}), 32'd0);
        #9;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // Decode sweep over opcodes 0..14, checked as each passes ex, mem and wb
        for (int cyc = 0; cyc <= 18; cyc++) begin
            check("sweep_ex", 32'({a_ex_alu_op, a_ex_alu_src, a_ex_load_partial, a_ex_flag_nv_en,
                                   a_ex_flag_z_en, a_ex_branch, a_ex_branch_reg}), 32'(exp_ex(cyc - 1)));
            check("sweep_mem", 32'({a_mem_read, a_mem_write}), 32'(exp_mem(cyc - 2)));
            check("sweep_wb", 32'({a_wb_reg_write, a_wb_mem_to_reg, a_wb_save_pc}), 32'(exp_wb(cyc - 3)));
            if (cyc <= 14) begin
                a_opcode   = 4'(cyc);
                a_in_valid = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
        end
        check("sweep_retired", 32'(a_retired), 32'd15);

        // ADD then LW back to back
        a_opcode = 4'b0000; a_in_valid = 1'b1;
        #1 check("addlw_acc0", 32'(a_accept), 32'd1);
        tick();
        check("addlw_ex_op", 32'(a_ex_alu_op), 32'd0);
        check("addlw_ex_nv", 32'(a_ex_flag_nv_en), 32'd1);
        a_opcode = 4'b1000;
        #1 check("addlw_acc1", 32'(a_accept), 32'd1);
        tick();
        check("addlw_ex_src", 32'(a_ex_alu_src), 32'd1);
        check("addlw_mem_add", 32'(a_mem_read), 32'd0);
        a_in_valid = 1'b0;
        tick();
        check("addlw_mem_lw", 32'(a_mem_read), 32'd1);
        check("addlw_wb_add", 32'({a_wb_reg_write, a_wb_mem_to_reg}), 32'b10);
        check("addlw_ret0", 32'(a_retired), 32'd15);
        tick();
        check("addlw_wb_lw", 32'({a_wb_reg_write, a_wb_mem_to_reg}), 32'b11);
        check("addlw_ret1", 32'(a_retired), 32'd16);
        tick();
        check("addlw_ret2", 32'(a_retired), 32'd17);
        check("addlw_wb_idle", 32'(a_wb_reg_write), 32'd0);

        // SW held by a two-cycle stall
        a_opcode = 4'b1001; a_in_valid = 1'b1;
        #1 check("sw_acc", 32'(a_accept), 32'd1);
        tick();
        check("sw_ex1", 32'(a_ex_alu_src), 32'd1);
        a_opcode = 4'b0000; a_stall = 1'b1;
        #1 check("sw_stall_acc1", 32'(a_accept), 32'd0);
        tick();
        check("sw_hold1", 32'(a_ex_alu_src), 32'd1);
        check("sw_bubble1", 32'(a_mem_write), 32'd0);
        check("sw_stall_acc2", 32'(a_accept), 32'd0);
        tick();
        check("sw_hold2", 32'(a_ex_alu_src), 32'd1);
        check("sw_bubble2", 32'(a_mem_write), 32'd0);
        a_stall = 1'b0; a_in_valid = 1'b0;
        tick();
        check("sw_mem", 32'(a_mem_write), 32'd1);
        check("sw_ex_clear", 32'(a_ex_alu_src), 32'd0);
        tick();
        check("sw_mem_once", 32'(a_mem_write), 32'd0);
        tick();
        check("sw_ret", 32'(a_retired), 32'd18);

        // PCS in stage 1 hit by flush and stall together
        a_opcode = 4'b1110; a_in_valid = 1'b1;
        #1 check("pcs_acc", 32'(a_accept), 32'd1);
        tick();
        check("pcs_ex", 32'(a_ex_alu_src), 32'd1);
        a_flush = 1'b1; a_stall = 1'b1;
        #1 check("pcs_flush_acc", 32'(a_accept), 32'd0);
        tick();
        check("pcs_killed", 32'(a_ex_alu_src), 32'd0);
        a_flush = 1'b0; a_stall = 1'b0; a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("pcs_no_save", 32'(a_wb_save_pc), 32'd0);
            tick();
        end
        check("pcs_ret", 32'(a_retired), 32'd18);

        // HLT killed by flush in stage 1, then ADD flows normally
        a_opcode = 4'b1111; a_in_valid = 1'b1;
        #1 check("hltf_acc", 32'(a_accept), 32'd1);
        tick();
        a_flush = 1'b1; a_opcode = 4'b0000;
        #1 check("hltf_flush_acc", 32'(a_accept), 32'd0);
        tick();
        a_flush = 1'b0;
        #1 check("hltf_run_acc", 32'(a_accept), 32'd1);
        tick();
        a_in_valid = 1'b0;
        check("hltf_add_ex", 32'(a_ex_flag_nv_en), 32'd1);
        repeat (3) tick();
        check("hltf_ret", 32'(a_retired), 32'd19);
        check("hltf_halted", 32'(a_halted), 32'd0);

        // HLT drains to HALTED with in_valid held high
        a_opcode = 4'b1111; a_in_valid = 1'b1;
        #1 check("hlt_acc", 32'(a_accept), 32'd1);
        tick();
        a_opcode = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("hlt_drain_acc", 32'(a_accept), 32'd0);
            check("hlt_drain_halted", 32'(a_halted), 32'd0);
            check("hlt_no_write", 32'({a_mem_write, a_wb_reg_write}), 32'd0);
            tick();
        end
        check("hlt_halted", 32'(a_halted), 32'd1);
        check("hlt_ret", 32'(a_retired), 32'd20);
        check("hlt_halted_acc", 32'(a_accept), 32'd0);
        repeat (3) tick();
        check("hlt_ret_frozen", 32'(a_retired), 32'd20);
        check("hlt_stays", 32'(a_halted), 32'd1);
        check("hlt_ex_bubble", 32'(a_ex_alu_src), 32'd0);

        // Asynchronous reset out of HALTED
        a_in_valid = 1'b0;
        a_rst_n = 1'b0;
        #1;
        check("rst2_halted", 32'(a_halted), 32'd0);
        check("rst2_retired", 32'(a_retired), 32'd0);
        #1 a_rst_n = 1'b1;
        tick();

        // Reset while HLT sits in stage 1
        a_opcode = 4'b1111; a_in_valid = 1'b1;
        #1 check("rstd_acc", 32'(a_accept), 32'd1);
        tick();
        a_in_valid = 1'b0;
        check("rstd_ex_hlt", 32'(a_ex_alu_src), 32'd1);
        a_rst_n = 1'b0;
        #1 check("rstd_ex_clear", 32'(a_ex_alu_src), 32'd0);
        #1 a_rst_n = 1'b1;
        tick();
        a_opcode = 4'b0000; a_in_valid = 1'b1;
        #1 check("rstd_run_acc", 32'(a_accept), 32'd1);
        tick();
        a_in_valid = 1'b0;
        repeat (3) tick();
        check("rstd_ret", 32'(a_retired), 32'd1);
        check("rstd_halted", 32'(a_halted), 32'd0);

        // STAGES=5, CNT_W=4: 17 ADDs wrap the counter to 1
        for (int k = 0; k < 17; k++) begin
            b_opcode = 4'b0000; b_in_valid = 1'b1;
            #1;
            if (b_accept === 1'b1) acc_cnt++;
            tick();
        end
        b_in_valid = 1'b0;
        repeat (6) tick();
        check("wrap_accepts", 32'(acc_cnt), 32'd17);
        check("wrap_ret", 32'(b_retired), 32'd1);

        // STAGES=5 ADD then LW latency
        b_opcode = 4'b0000; b_in_valid = 1'b1;
        #1 check("s5_acc0", 32'(b_accept), 32'd1);
        tick();
        check("s5_ex_add", 32'({b_ex_alu_op, b_ex_flag_nv_en}), 32'b0001);
        b_opcode = 4'b1000;
        #1 check("s5_acc1", 32'(b_accept), 32'd1);
        tick();
        check("s5_ex_lw", 32'(b_ex_alu_src), 32'd1);
        b_in_valid = 1'b0;
        tick();
        tick();
        check("s5_mem_early", 32'({b_mem_read, b_wb_reg_write}), 32'd0);
        tick();
        check("s5_mem_lw", 32'(b_mem_read), 32'd1);
        check("s5_wb_add", 32'({b_wb_reg_write, b_wb_mem_to_reg}), 32'b10);
        tick();
        check("s5_wb_lw", 32'({b_wb_reg_write, b_wb_mem_to_reg}), 32'b11);
        check("s5_mem_idle", 32'(b_mem_read), 32'd0);
        check("s5_ret1", 32'(b_retired), 32'd2);
        tick();
        check("s5_ret2", 32'(b_retired), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
